// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter that shares the UART TX FIFO write port between
// NUM_REQ byte sources. The grant is held for a whole packet (req_last)
// or until MAX_BURST bytes have been written. All activity is qualified
// by the enable_clk tick.
//
// Handshake: a byte of requester i moves into the FIFO on a clock edge
// where req_valid[i] & req_ready[i] is high. req_ready is combinational
// and only the current owner can see it high. fifo_wr_en is asserted on
// exactly those cycles. fifo_wr_data carries the owner's byte in the same
// cycle, with no added latency.
module uart_tx_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable_clk,
    input  logic [NUM_REQ-1:0]        req_valid,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic [NUM_REQ-1:0]        req_last,
    output logic [NUM_REQ-1:0]        req_ready,
    input  logic                      fifo_full,
    output logic                      fifo_wr_en,
    output logic [DATA_W-1:0]         fifo_wr_data,
    output logic [NUM_REQ-1:0]        grant,
    output logic                      busy,
    output logic [0:0]                dbg_state
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W:0] NUM_REQ_W = (PTR_W + 1)'(NUM_REQ);
    localparam logic [7:0] LAST_CNT = 8'(MAX_BURST - 1);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_GRANT = 1'b1;

    logic [0:0]       state;
    logic [PTR_W-1:0] rr_ptr;
    logic [PTR_W-1:0] owner;
    logic [7:0]       burst_cnt;

    logic             found;
    logic [PTR_W-1:0] pick;
    logic             tick_ok;
    logic             xfer;
    logic             release_now;
    logic [PTR_W-1:0] next_ptr;

    // Pick the first valid requester at or above rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        pick  = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            logic [PTR_W:0] sum;
            logic [PTR_W-1:0] cand;
            sum = {1'b0, rr_ptr} + (PTR_W + 1)'(k);
            if (sum >= NUM_REQ_W) begin
                sum = sum - NUM_REQ_W;
            end
            cand = sum[PTR_W-1:0];
            if (!found && req_valid[cand]) begin
                found = 1'b1;
                pick  = cand;
            end
        end
    end

    // Select the owner's byte for the FIFO write port.
    always_comb begin
        fifo_wr_data = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner == PTR_W'(i)) begin
                fifo_wr_data = req_data[i*DATA_W +: DATA_W];
            end
        end
    end

    // Handshake and release decode; reset suppresses any write that cycle.
    always_comb begin
        tick_ok     = (state == ST_GRANT) && enable_clk && !fifo_full && !rst;
        req_ready   = tick_ok ? grant : '0;
        xfer        = tick_ok && req_valid[owner];
        fifo_wr_en  = xfer;
        release_now = xfer && (req_last[owner] || (burst_cnt == LAST_CNT));
        next_ptr    = (owner == PTR_W'(NUM_REQ - 1)) ? '0 : owner + PTR_W'(1);
    end

    assign dbg_state = state;

    // Arbitration FSM, grant/busy registers, burst counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            grant     <= '0;
            busy      <= 1'b0;
            rr_ptr    <= '0;
            owner     <= '0;
            burst_cnt <= '0;
        end else if (enable_clk) begin
            case (state)
                ST_IDLE: begin
                    if (found) begin
                        state     <= ST_GRANT;
                        owner     <= pick;
                        grant     <= {{(NUM_REQ-1){1'b0}}, 1'b1} << pick;
                        busy      <= 1'b1;
                        burst_cnt <= '0;
                    end
                end
                ST_GRANT: begin
                    if (xfer) begin
                        burst_cnt <= burst_cnt + 8'd1;
                    end
                    if (release_now) begin
                        state  <= ST_IDLE;
                        grant  <= '0;
                        busy   <= 1'b0;
                        rr_ptr <= next_ptr;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                    grant <= '0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
